// File: rtl/seq_divider_if.sv
// Operand/result bundle for the sequential divider.
// The ALU sequencer owns the master side; the divider owns the slave side.

// Handshake: start is sampled on a rising edge and is accepted only while the
// divider is idle or showing done; busy is high while a quotient is being
// iterated (start is ignored then); done is a one-cycle strobe marking the
// first cycle in which quotient/remainder/div_by_zero hold the new result.
// Results stay on the bus until the next accepted operation completes.
interface seq_divider_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per clock, W steps per operation,
// registered results and a one-cycle done strobe. Divide-by-zero bypasses the loop.
module seq_divider #(
  parameter int W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  seq_divider_if.slave bus,
  output logic [1:0] dbg_state
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  // The restored remainder is always below the divisor, so W bits suffice;
  // only the shifted trial value needs the extra bit.
  logic [W-1:0]  r;
  logic [W-1:0]  q;
  logic [W-1:0]  d;
  logic [CW-1:0] cnt;

  logic          accept;
  logic          last_step;
  logic [W:0]    shifted;
  logic [W:0]    diff;
  logic          fits;
  logic [W-1:0]  r_step;
  logic [W-1:0]  q_step;

  logic [W-1:0]  quotient_r;
  logic [W-1:0]  remainder_r;
  logic          div_by_zero_r;

  assign accept    = bus.start && ((state == IDLE) || (state == DONE));
  assign last_step = (cnt == CW'(W - 1));

  // A borrow out of the W+1-bit subtraction means the trial value is below D.
  assign shifted = {r, q[W-1]};
  assign diff    = shifted - {1'b0, d};
  assign fits    = ~diff[W];
  assign r_step  = fits ? diff[W-1:0] : shifted[W-1:0];
  assign q_step  = {q[W-2:0], fits};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_nxt = (bus.divisor != '0) ? CALC : DONE;
        end else begin
          state_nxt = IDLE;
        end
      end
      CALC: begin
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r             <= '0;
      q             <= '0;
      d             <= '0;
      cnt           <= '0;
      quotient_r    <= '0;
      remainder_r   <= '0;
      div_by_zero_r <= 1'b0;
    end else if (accept) begin
      if (bus.divisor != '0) begin
        r   <= '0;
        q   <= bus.dividend;
        d   <= bus.divisor;
        cnt <= '0;
      end else begin
        quotient_r    <= '1;
        remainder_r   <= bus.dividend;
        div_by_zero_r <= 1'b1;
      end
    end else if (state == CALC) begin
      r   <= r_step;
      q   <= q_step;
      cnt <= cnt + CW'(1);
      if (last_step) begin
        quotient_r    <= q_step;
        remainder_r   <= r_step;
        div_by_zero_r <= 1'b0;
      end
    end
  end

  // busy/done decode straight from the state register, so no input reaches them.
  assign bus.busy        = (state == CALC);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = div_by_zero_r;
  assign dbg_state       = state;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: arithmetic reference model with cycle-accurate
// done/busy expectations, checked every cycle, plus literal result checks.
module tb_seq_divider;

  localparam int W = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_divider_if #(.W(W)) bus ();
  logic [1:0] dbg_state;

  seq_divider #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_r_q[$];
  logic         exp_z_q[$];
  int           exp_due_q[$];

  logic [W-1:0] held_q = '0;
  logic [W-1:0] held_r = '0;
  logic         held_z = 1'b0;
  int           busy_start = 0;
  int           busy_end = 0;
  int           last_due = 0;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", {31'd0, bus.busy}, {31'd0, (cyc >= busy_start) && (cyc < busy_end)});
      if (exp_due_q.size() > 0 && exp_due_q[0] == cyc) begin
        chk("done", {31'd0, bus.done}, 32'd1);
        held_q = exp_q.pop_front();
        held_r = exp_r_q.pop_front();
        held_z = exp_z_q.pop_front();
        void'(exp_due_q.pop_front());
      end else begin
        chk("done", {31'd0, bus.done}, 32'd0);
      end
      chk("quotient", {24'd0, bus.quotient}, {24'd0, held_q});
      chk("remainder", {24'd0, bus.remainder}, {24'd0, held_r});
      chk("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, held_z});
    end
  end

  // driver tasks
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    if (cyc >= last_due) begin
      n = cyc + 1;
      if (b == '0) begin
        busy_start = n;
        busy_end   = n;
        last_due   = n;
        exp_q.push_back('1);
        exp_r_q.push_back(a);
        exp_z_q.push_back(1'b1);
      end else begin
        busy_start = n;
        busy_end   = n + W;
        last_due   = n + W;
        exp_q.push_back(a / b);
        exp_r_q.push_back(a % b);
        exp_z_q.push_back(1'b0);
      end
      exp_due_q.push_back(last_due);
    end
    step();
    bus.start    = 1'b0;
    bus.dividend = W'($urandom_range(0, 255));
    bus.divisor  = W'($urandom_range(0, 255));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_due_q.size() != 0 || cyc <= last_due) && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout @cyc %0d: still waiting on %0d results", cyc, exp_due_q.size());
    end
  endtask

  task automatic wait_until(input int c);
    int n = 0;
    while (cyc < c && n < 40) begin
      step();
      n++;
    end
    chk("wait_until", cyc, c);
  endtask

  task automatic check_out(input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
    chk("lit_quotient", {24'd0, bus.quotient}, {24'd0, eq});
    chk("lit_remainder", {24'd0, bus.remainder}, {24'd0, er});
    chk("lit_div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, ez});
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
    issue(a, b);
    wait_idle();
    check_out(eq, er, ez);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst_n        = 1'b0;
    step();
    step();
    check_out('0, '0, 1'b0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    rst_n = 1'b1;
    step();

    // basic quotients and boundary operands
    run(8'd100, 8'd7,   8'd14,  8'd2,  1'b0);
    run(8'd255, 8'd1,   8'd255, 8'd0,  1'b0);
    run(8'd5,   8'd9,   8'd0,   8'd5,  1'b0);
    run(8'd200, 8'd200, 8'd1,   8'd0,  1'b0);
    run(8'd1,   8'd255, 8'd0,   8'd1,  1'b0);
    run(8'd255, 8'd2,   8'd127, 8'd1,  1'b0);
    run(8'd128, 8'd16,  8'd8,   8'd0,  1'b0);

    // divide by zero, then a normal op clears the flag
    run(8'd42, 8'd0, 8'hFF, 8'd42, 1'b1);
    run(8'd9,  8'd3, 8'd3,  8'd0,  1'b0);

    // start during CALC is ignored
    issue(8'd100, 8'd7);
    repeat (3) step();
    issue(8'd9, 8'd3);
    wait_idle();
    check_out(8'd14, 8'd2, 1'b0);

    // back-to-back accept in the done cycle
    issue(8'd100, 8'd7);
    wait_until(last_due);
    check_out(8'd14, 8'd2, 1'b0);
    issue(8'd50, 8'd6);
    wait_idle();
    check_out(8'd8, 8'd2, 1'b0);

    // asynchronous reset mid-CALC
    issue(8'd100, 8'd7);
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_out('0, '0, 1'b0);
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_done", {31'd0, bus.done}, 32'd0);
    exp_q.delete();
    exp_r_q.delete();
    exp_z_q.delete();
    exp_due_q.delete();
    held_q     = '0;
    held_r     = '0;
    held_z     = 1'b0;
    busy_start = 0;
    busy_end   = 0;
    last_due   = 0;
    step();
    rst_n = 1'b1;
    repeat (12) step();
    run(8'd77, 8'd10, 8'd7, 8'd7, 1'b0);

    repeat (3) step();
    chk("leftover", exp_due_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
